funct_fifo_reader: RTL

Consumer-side block for the function-generator sample FIFO. It pops one Q4.28 sample per programmable sample period, converts it to an offset-binary DAC code, and shifts the code out MSB-first on a 3-wire serial DAC interface (cs_n/sclk/sdo). It sits between the FIFO read port and the off-chip DAC, and flags underruns when a sample is due but the FIFO is empty.

---
 rtl/funct_fifo_reader.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/funct_fifo_reader.sv
// funct_fifo_reader: pops one signed fixed-point sample from the
// function-generator FIFO every sample period, converts it to an
// offset-binary DAC code and shifts it MSB-first to a 3-wire serial DAC.
// An underrun flag records sample ticks that found the FIFO empty.
module funct_fifo_reader #(
  parameter int DATA_WIDTH    = 32,
  parameter int INT_BITS      = 4,
  parameter int DAC_BITS      = 12,
  parameter int SCLK_DIV      = 2,
  parameter int SAMPLE_PERIOD = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  empty_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  clr_underrun_i,
  output logic                  rd_en_o,
  output logic                  cs_n_o,
  output logic                  sclk_o,
  output logic                  sdo_o,
  output logic                  busy_o,
  output logic                  underrun_o
);

  localparam int CNT_W = $clog2(SAMPLE_PERIOD);
  localparam int SUB_W = $clog2(2 * SCLK_DIV);
  localparam int BIT_W = (DAC_BITS > 1) ? $clog2(DAC_BITS) : 1;

  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [SUB_W-1:0]    SUB_LAST = SUB_W'(2 * SCLK_DIV - 1);
  localparam logic [SUB_W-1:0]    SUB_HIGH = SUB_W'(SCLK_DIV);
  localparam logic [BIT_W-1:0]    BIT_LAST = BIT_W'(DAC_BITS - 1);
  localparam logic [DAC_BITS-1:0] MSB_MASK = DAC_BITS'(1) << (DAC_BITS - 1);

  // Parameter sanity: a frame must fit inside one sample period.
  generate
    if ((DAC_BITS < 1) || (DAC_BITS > DATA_WIDTH) || (SCLK_DIV < 1) ||
        (INT_BITS < 1) || (INT_BITS > DATA_WIDTH) ||
        (SAMPLE_PERIOD < 2 * SCLK_DIV * DAC_BITS + 3)) begin : g_bad_params
      $error("funct_fifo_reader: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LATCH = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Two's complement to offset binary is just an MSB flip of the top bits.
  function automatic logic [DAC_BITS-1:0] to_dac_code(input logic [DAC_BITS-1:0] top);
    return top ^ MSB_MASK;
  endfunction

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SUB_W-1:0]      sub_q, sub_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DAC_BITS-1:0]   shreg_q, shreg_d;
  logic                  underrun_q, underrun_d;
  logic                  rd_en_q, rd_en_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  sdo_q, sdo_d;
  logic                  busy_q, busy_d;
  logic                  tick_s;
  logic                  set_underrun_s;

  // FIFO bits below the DAC resolution are intentionally discarded.
  logic unused_data_s;
  assign unused_data_s = ^data_i;

  assign tick_s = en_i && (cnt_q == {CNT_W{1'b0}});

  // Sample-period counter: parked at zero while disabled, wraps each period.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Frame sequencer next-state, shift datapath and underrun flag.
  always_comb begin
    state_d        = state_q;
    sub_d          = sub_q;
    bit_d          = bit_q;
    shreg_d        = shreg_q;
    set_underrun_s = 1'b0;
    underrun_d     = underrun_q;
    case (state_q)
      S_IDLE: begin
        if (tick_s) begin
          if (empty_i) begin
            set_underrun_s = 1'b1;
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        shreg_d = to_dac_code(data_i[DATA_WIDTH-1 -: DAC_BITS]);
        sub_d   = {SUB_W{1'b0}};
        bit_d   = {BIT_W{1'b0}};
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (sub_q == SUB_LAST) begin
          sub_d   = {SUB_W{1'b0}};
          shreg_d = shreg_q << 1'b1;
          if (bit_q == BIT_LAST) begin
            bit_d   = {BIT_W{1'b0}};
            state_d = S_DONE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A new underrun takes priority over a simultaneous clear.
    if (set_underrun_s) begin
      underrun_d = 1'b1;
    end else if (clr_underrun_i) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  // Output values derived from the next state so the pins come straight from flops.
  always_comb begin
    rd_en_d = (state_d == S_READ);
    cs_n_d  = (state_d != S_SHIFT);
    sclk_d  = (state_d == S_SHIFT) && (sub_d >= SUB_HIGH);
    busy_d  = (state_d != S_IDLE);
    if (state_d == S_SHIFT) begin
      sdo_d = shreg_d[DAC_BITS-1];
    end else begin
      sdo_d = 1'b0;
    end
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      sub_q      <= {SUB_W{1'b0}};
      bit_q      <= {BIT_W{1'b0}};
      shreg_q    <= {DAC_BITS{1'b0}};
      underrun_q <= 1'b0;
      rd_en_q    <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      sdo_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sub_q      <= sub_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      underrun_q <= underrun_d;
      rd_en_q    <= rd_en_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      sdo_q      <= sdo_d;
      busy_q     <= busy_d;
    end
  end

  assign rd_en_o    = rd_en_q;
  assign cs_n_o     = cs_n_q;
  assign sclk_o     = sclk_q;
  assign sdo_o      = sdo_q;
  assign busy_o     = busy_q;
  assign underrun_o = underrun_q;

endmodule
